// File: rtl/data_memory.sv
// Word-organised data memory with fixed access latency, byte/halfword/word loads and stores,
// and misalignment/illegal-encoding fault reporting. The FSM state is visible on state_dbg.
module data_memory #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        busy,
   output logic        done,
   output logic        accessFault,
   output logic [1:0]  state_dbg
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Handshake: a request (memRead|memWrite) is taken in IDLE; busy stays high until the
   // DONE cycle, where done pulses for exactly one cycle and the pipeline may advance.

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          write_q, write_d;
   logic [2:0]    f3_q, f3_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          fault_q, fault_d;
   logic [31:0]   rdata_q, rdata_d;

   logic [31:0]   mem [DEPTH_WORDS];

   logic          req;
   logic [AW-1:0] word_idx;
   logic [31:0]   mem_word;
   logic [7:0]    sel_byte;
   logic [15:0]   sel_half;
   logic [31:0]   load_val;
   logic [31:0]   store_word;
   logic          mem_we;
   logic          unused_addr_hi;

   function automatic logic legal_access(input logic wr, input logic [2:0] f3,
                                         input logic [1:0] a);
      logic ok_type;
      logic aligned;
      if (wr) ok_type = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
      else    ok_type = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      case (f3[1:0])
         2'b01:   aligned = ~a[0];
         2'b10:   aligned = (a == 2'b00);
         default: aligned = 1'b1;
      endcase
      return ok_type & aligned;
   endfunction

   assign req            = memRead | memWrite;
   assign word_idx       = addr_q[AW+1:2];
   assign mem_word       = mem[word_idx];
   assign unused_addr_hi = &{1'b0, address[31:AW+2]};

   always_comb begin
      case (addr_q[1:0])
         2'b00:   sel_byte = mem_word[7:0];
         2'b01:   sel_byte = mem_word[15:8];
         2'b10:   sel_byte = mem_word[23:16];
         default: sel_byte = mem_word[31:24];
      endcase
      sel_half = addr_q[1] ? mem_word[31:16] : mem_word[15:0];
      case (f3_q)
         3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
         3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
         3'b100:  load_val = {24'd0, sel_byte};
         3'b101:  load_val = {16'd0, sel_half};
         default: load_val = mem_word;
      endcase
   end

   // Stores merge the new lane into the current word so one full-word write suffices.
   always_comb begin
      store_word = mem_word;
      case (f3_q[1:0])
         2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: store_word = wdata_q;
      endcase
   end

   assign mem_we = (state_q == ST_WAIT) && (cnt_q == '0) && write_q && !reset;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      fault_d = fault_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               write_d = memWrite;
               f3_d    = funct3;
               addr_d  = address[AW+1:0];
               wdata_d = writeData;
               if (legal_access(memWrite, funct3, address[1:0])) begin
                  cnt_d   = CW'(LATENCY - 1);
                  fault_d = 1'b0;
                  state_d = ST_WAIT;
               end else begin
                  fault_d = 1'b1;
                  rdata_d = '0;
                  state_d = ST_DONE;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               if (!write_q) rdata_d = load_val;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         fault_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         fault_q <= fault_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clock) begin
      if (mem_we) mem[word_idx] <= store_word;
   end

   assign readData    = rdata_q;
   assign busy        = !reset && (((state_q == ST_IDLE) && req) || (state_q == ST_WAIT));
   assign done        = (state_q == ST_DONE);
   assign accessFault = (state_q == ST_DONE) && fault_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: byte-array reference model, per-cycle output checks and a
// completion scoreboard, driven by directed cases followed by randomized accesses.
module tb_data_memory;

   localparam int DEPTH_WORDS = 256;
   localparam int LATENCY     = 2;
   localparam int MEM_BYTES   = DEPTH_WORDS * 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic        clock = 1'b0;
   logic        reset;
   logic        memRead;
   logic        memWrite;
   logic [2:0]  funct3;
   logic [31:0] address;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        busy;
   logic        done;
   logic        accessFault;
   logic [1:0]  state_dbg;

   // clock / reset
   always #5 clock = ~clock;

   data_memory #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
      .clock(clock), .reset(reset), .memRead(memRead), .memWrite(memWrite),
      .funct3(funct3), .address(address), .writeData(writeData),
      .readData(readData), .busy(busy), .done(done), .accessFault(accessFault),
      .state_dbg(state_dbg)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  model_mem [MEM_BYTES];
   logic [31:0] exp_q [$];
   logic [31:0] exp_rdata;
   logic        exp_busy, exp_done, exp_fault;
   logic [1:0]  exp_state;
   bit          cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model
   function automatic bit legal(input bit wr, input logic [2:0] f3, input logic [31:0] a);
      bit typ;
      int nbytes;
      if (wr) typ = (f3 <= 3'd2);
      else    typ = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      nbytes = 1 << f3[1:0];
      return typ && ((a % nbytes) == 0);
   endfunction

   function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a);
      int b;
      b = int'(a & (MEM_BYTES - 1));
      case (f3)
         3'd0:    return {{24{model_mem[b][7]}}, model_mem[b]};
         3'd1:    return {{16{model_mem[b+1][7]}}, model_mem[b+1], model_mem[b]};
         3'd4:    return {24'd0, model_mem[b]};
         3'd5:    return {16'd0, model_mem[b+1], model_mem[b]};
         default: return {model_mem[b+3], model_mem[b+2], model_mem[b+1], model_mem[b]};
      endcase
   endfunction

   task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      int b;
      int n;
      b = int'(a & (MEM_BYTES - 1));
      n = 1 << f3[1:0];
      for (int i = 0; i < n; i++) model_mem[b+i] = wd[8*i +: 8];
   endtask

   // per-cycle compare and completion scoreboard
   always @(negedge clock) begin
      if (cmp_en) begin
         chk("busy", {31'd0, busy}, {31'd0, exp_busy});
         chk("done", {31'd0, done}, {31'd0, exp_done});
         chk("accessFault", {31'd0, accessFault}, {31'd0, exp_fault});
         chk("state", {30'd0, state_dbg}, {30'd0, exp_state});
         chk("readData", readData, exp_rdata);
         if (done) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL sb_unexpected_done: got done=1, expected no completion at %0t", $time);
            end else begin
               chk("sb_readData", readData, exp_q.pop_front());
            end
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_idle_exp();
      memRead   = 1'b0;
      memWrite  = 1'b0;
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      exp_fault = 1'b0;
      exp_state = S_IDLE;
   endtask

   task automatic idle_cycle();
      set_idle_exp();
      tick();
   endtask

   task automatic access(input bit wr, input bit rd, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input bit abort);
      bit ok;
      ok        = legal(wr, f3, a);
      memWrite  = wr;
      memRead   = rd;
      funct3    = f3;
      address   = a;
      writeData = wd;
      exp_busy  = 1'b1;
      exp_done  = 1'b0;
      exp_fault = 1'b0;
      exp_state = S_IDLE;
      tick();
      // inputs after acceptance belong to the same instruction and must be ignored
      memRead   = 1'($urandom_range(0, 1));
      memWrite  = 1'($urandom_range(0, 1));
      funct3    = 3'($urandom_range(0, 7));
      address   = $urandom;
      writeData = $urandom;
      if (ok) begin
         for (int i = 1; i <= LATENCY; i++) begin
            exp_state = S_WAIT;
            exp_busy  = 1'b1;
            if (abort && i == LATENCY) begin
               reset    = 1'b1;
               exp_busy = 1'b0;
            end
            tick();
         end
         if (abort) begin
            reset     = 1'b0;
            exp_rdata = '0;
            set_idle_exp();
            return;
         end
      end
      if (!ok)     exp_rdata = '0;
      else if (wr) model_store(f3, a, wd);
      else         exp_rdata = load_val(f3, a);
      exp_q.push_back(exp_rdata);
      exp_state = S_DONE;
      exp_busy  = 1'b0;
      exp_done  = 1'b1;
      exp_fault = !ok;
      tick();
      set_idle_exp();
   endtask

   task automatic pin(input string name, input logic [31:0] lit);
      chk(name, readData, lit);
      chk({name, "_model"}, exp_rdata, lit);
   endtask

   initial begin
      reset     = 1'b1;
      memRead   = 1'b1;
      memWrite  = 1'b0;
      funct3    = 3'd2;
      address   = '0;
      writeData = '0;
      exp_rdata = '0;
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      exp_fault = 1'b0;
      exp_state = S_IDLE;
      tick();
      cmp_en = 1'b1;
      tick();
      reset = 1'b0;
      idle_cycle();

      for (int w = 0; w < DEPTH_WORDS; w++) access(1'b1, 1'b0, 3'd2, 32'(w * 4), $urandom, 1'b0);

      access(1'b1, 1'b0, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0);
      access(1'b0, 1'b1, 3'd2, 32'h10, 32'h0, 1'b0);
      pin("lw_basic", 32'hDEADBEEF);

      access(1'b1, 1'b0, 3'd2, 32'h20, 32'h80FF7F01, 1'b0);
      access(1'b0, 1'b1, 3'd0, 32'h23, 32'h0, 1'b0);
      pin("lb_sext", 32'hFFFFFF80);
      access(1'b0, 1'b1, 3'd4, 32'h23, 32'h0, 1'b0);
      pin("lbu_zext", 32'h00000080);
      access(1'b0, 1'b1, 3'd1, 32'h22, 32'h0, 1'b0);
      pin("lh_sext", 32'hFFFF80FF);
      access(1'b0, 1'b1, 3'd5, 32'h20, 32'h0, 1'b0);
      pin("lhu_zext", 32'h00007F01);
      access(1'b1, 1'b0, 3'd0, 32'h21, 32'h123456AA, 1'b0);
      access(1'b0, 1'b1, 3'd2, 32'h20, 32'h0, 1'b0);
      pin("sb_merge", 32'h80FFAA01);

      access(1'b0, 1'b1, 3'd2, 32'h22, 32'h0, 1'b0);
      pin("lw_misaligned", 32'h0);
      access(1'b1, 1'b0, 3'd2, 32'h30, 32'h0BADF00D, 1'b0);
      access(1'b1, 1'b0, 3'd1, 32'h31, 32'h0000FFFF, 1'b0);
      access(1'b0, 1'b1, 3'd2, 32'h30, 32'h0, 1'b0);
      pin("sh_fault_no_write", 32'h0BADF00D);
      access(1'b0, 1'b1, 3'd3, 32'h30, 32'h0, 1'b0);
      pin("f3_011_fault", 32'h0);

      access(1'b1, 1'b0, 3'd2, 32'h40, 32'hCAFEF00D, 1'b0);
      access(1'b1, 1'b0, 3'd2, 32'h40, 32'h12345678, 1'b1);
      idle_cycle();
      pin("abort_rdata", 32'h0);
      access(1'b0, 1'b1, 3'd2, 32'h40, 32'h0, 1'b0);
      pin("abort_no_write", 32'hCAFEF00D);

      access(1'b1, 1'b0, 3'd2, 32'h404, 32'h5A5AA5A5, 1'b0);
      access(1'b0, 1'b1, 3'd2, 32'h004, 32'h0, 1'b0);
      pin("wrap", 32'h5A5AA5A5);
      access(1'b1, 1'b1, 3'd2, 32'h50, 32'h11223344, 1'b0);
      pin("prio_rdata_hold", 32'h5A5AA5A5);
      access(1'b0, 1'b1, 3'd2, 32'h50, 32'h0, 1'b0);
      pin("prio_store_done", 32'h11223344);

      for (int n = 0; n < 400; n++) begin
         int          sel;
         logic [2:0]  f3;
         logic [31:0] a;
         sel = $urandom_range(0, 2);
         if ($urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 4))
               0:       f3 = 3'd0;
               1:       f3 = 3'd1;
               2:       f3 = 3'd2;
               3:       f3 = 3'd4;
               default: f3 = 3'd5;
            endcase
         end else begin
            f3 = 3'($urandom_range(0, 7));
         end
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         access(sel != 0, sel != 1, f3, a, $urandom, 1'b0);
         if ($urandom_range(0, 4) == 0) idle_cycle();
      end

      idle_cycle();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      miscompares++;
      $display("FAIL watchdog: got no end of stimulus, expected completion before %0t", $time);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog expired");
   end

endmodule
